// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and
// a slow block memory. Misses stall the pipeline while a 256-bit line is written back and/or filled.
module dcache_controller #(
  parameter int INDEX_BITS    = 4,
  parameter int WORD_SEL_BITS = 3,
  parameter int TAG_BITS      = 23
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [31:0]                       cpu_addr_i,
  input  logic [31:0]                       cpu_data_i,
  input  logic                              cpu_MemRead_i,
  input  logic                              cpu_MemWrite_i,
  output logic [31:0]                       cpu_data_o,
  output logic                              cpu_stall_o,
  output logic [31:0]                       mem_addr_o,
  output logic [(32<<WORD_SEL_BITS)-1:0]    mem_data_o,
  output logic                              mem_enable_o,
  output logic                              mem_write_o,
  input  logic [(32<<WORD_SEL_BITS)-1:0]    mem_data_i,
  input  logic                              mem_ack_i
);

  localparam int LINES   = 1 << INDEX_BITS;
  localparam int BLOCK_W = 32 << WORD_SEL_BITS;
  localparam int OFF_W   = WORD_SEL_BITS + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_ALLOCATE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;

  logic [LINES-1:0]          r_valid;
  logic [LINES-1:0]          r_dirty;
  logic [TAG_BITS-1:0]       r_tag  [LINES];
  logic [BLOCK_W-1:0]        r_data [LINES];

  logic [TAG_BITS-1:0]       w_tag;
  logic [INDEX_BITS-1:0]     w_idx;
  logic [WORD_SEL_BITS-1:0]  w_word;
  logic [WORD_SEL_BITS+4:0]  w_bit_off;
  logic                      w_req;
  logic                      w_hit;
  logic                      w_idle_hit;
  logic                      w_wr_hit;
  logic                      w_fill;
  logic                      w_unused;

  assign w_tag     = cpu_addr_i[31 -: TAG_BITS];
  assign w_idx     = cpu_addr_i[OFF_W +: INDEX_BITS];
  assign w_word    = cpu_addr_i[2 +: WORD_SEL_BITS];
  assign w_bit_off = {w_word, 5'b0};
  // Byte offset bits are ignored: all accesses are full words.
  assign w_unused  = ^cpu_addr_i[1:0];

  assign w_req      = cpu_MemRead_i | cpu_MemWrite_i;
  assign w_hit      = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_idle_hit = (r_state == S_IDLE) & w_hit;
  assign w_wr_hit   = w_idle_hit & cpu_MemWrite_i;
  assign w_fill     = (r_state == S_ALLOCATE) & mem_ack_i;

  assign cpu_stall_o = w_req & ~w_idle_hit;
  // A simultaneous read+write is a store, so it returns no load data.
  assign cpu_data_o  = (w_idle_hit & cpu_MemRead_i & ~cpu_MemWrite_i)
                       ? r_data[w_idx][w_bit_off +: 32] : 32'h0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_next;
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end else if (w_wr_hit) begin
        r_dirty[w_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (w_fill) begin
      r_data[w_idx] <= mem_data_i;
      r_tag[w_idx]  <= w_tag;
    end else if (w_wr_hit) begin
      r_data[w_idx][w_bit_off +: 32] <= cpu_data_i;
    end
  end

  always_comb begin
    w_next       = r_state;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0;
    mem_data_o   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req & ~w_hit) w_next = S_MISS;
      end
      S_MISS: begin
        w_next = (r_valid[w_idx] & r_dirty[w_idx]) ? S_WRITEBACK : S_ALLOCATE;
      end
      S_WRITEBACK: begin
        // The CPU holds its address, so the victim is still r_*[w_idx].
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {r_tag[w_idx], w_idx, {OFF_W{1'b0}}};
        mem_data_o   = r_data[w_idx];
        if (mem_ack_i) w_next = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {w_tag, w_idx, {OFF_W{1'b0}}};
        if (mem_ack_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: fills, hits, write-back, slow ack,
// reset during write-back and idle cycles, each step checked with an immediate assertion.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] blk_a;
  logic [255:0] blk_b;

  dcache_controller dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_data_i    (cpu_data_i),
    .cpu_MemRead_i (cpu_MemRead_i),
    .cpu_MemWrite_i(cpu_MemWrite_i),
    .cpu_data_o    (cpu_data_o),
    .cpu_stall_o   (cpu_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      blk_a[i*32 +: 32] = 32'h1000_0000 + i;
      blk_b[i*32 +: 32] = 32'h2000_0000 + i;
    end
    blk_a[63:32] = 32'h1234_5678;
    blk_a[95:64] = 32'hCAFE_F00D;
    blk_b[63:32] = 32'hAAAA_0001;

    rst_i = 1'b1; cpu_addr_i = 32'h0; cpu_data_i = 32'h0;
    cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
    mem_data_i = '0; mem_ack_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
    #1;
    check("rst_stall",  cpu_stall_o,  0);
    check("rst_data",   cpu_data_o,   0);
    check("rst_en",     mem_enable_o, 0);
    check("rst_wr",     mem_write_o,  0);
    check("rst_addr",   mem_addr_o,   0);
    check("rst_mdata",  mem_data_o,   0);

    // Cold load miss, ack on the second ALLOCATE cycle: 4 stall cycles.
    cpu_addr_i = 32'h0000_0104; cpu_MemRead_i = 1'b1;
    #1;
    check("t1_stall_idle", cpu_stall_o, 1);
    check("t1_en_idle",    mem_enable_o, 0);
    step();
    check("t1_stall_miss", cpu_stall_o, 1);
    check("t1_en_miss",    mem_enable_o, 0);
    step();
    check("t1_stall_al1",  cpu_stall_o, 1);
    check("t1_en_al1",     mem_enable_o, 1);
    check("t1_wr_al1",     mem_write_o, 0);
    check("t1_addr_al1",   mem_addr_o, 32'h0000_0100);
    step();
    mem_data_i = blk_a; mem_ack_i = 1'b1;
    #1;
    check("t1_stall_al2",  cpu_stall_o, 1);
    step();
    mem_ack_i = 1'b0;
    #1;
    check("t1_stall_rel",  cpu_stall_o, 0);
    check("t1_data_rel",   cpu_data_o, 32'h1234_5678);

    // Hit on another word of the same line.
    cpu_addr_i = 32'h0000_0108;
    #1;
    check("t2_stall", cpu_stall_o, 0);
    check("t2_en",    mem_enable_o, 0);
    check("t2_data",  cpu_data_o, 32'hCAFE_F00D);

    // Store hit, then conflicting load forces write-back of the dirty line.
    cpu_addr_i = 32'h0000_0104; cpu_data_i = 32'hDEAD_BEEF;
    cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b1;
    #1;
    check("t3_st_stall", cpu_stall_o, 0);
    check("t3_st_data",  cpu_data_o, 0);
    step();
    cpu_MemWrite_i = 1'b0; cpu_MemRead_i = 1'b1; cpu_addr_i = 32'h0000_0304;
    #1;
    check("t3_stall_idle", cpu_stall_o, 1);
    step();
    check("t3_en_miss", mem_enable_o, 0);
    step();
    check("t3_wb_en",   mem_enable_o, 1);
    check("t3_wb_wr",   mem_write_o, 1);
    check("t3_wb_addr", mem_addr_o, 32'h0000_0100);
    check("t3_wb_w1",   mem_data_o[63:32], 32'hDEAD_BEEF);
    check("t3_wb_w2",   mem_data_o[95:64], 32'hCAFE_F00D);
    check("t3_wb_stall", cpu_stall_o, 1);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    #1;
    // ALLOCATE with the ack held off for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      check("t4_en",    mem_enable_o, 1);
      check("t4_wr",    mem_write_o, 0);
      check("t4_addr",  mem_addr_o, 32'h0000_0300);
      check("t4_stall", cpu_stall_o, 1);
      step();
    end
    mem_data_i = blk_b; mem_ack_i = 1'b1;
    #1;
    check("t4_stall_ack", cpu_stall_o, 1);
    step();
    mem_ack_i = 1'b0;
    #1;
    check("t4_stall_rel", cpu_stall_o, 0);
    check("t4_data_rel",  cpu_data_o, 32'hAAAA_0001);

    // Line is now clean with tag 1: evicting it must skip WRITEBACK.
    cpu_addr_i = 32'h0000_0104;
    #1;
    check("t3_clean_stall", cpu_stall_o, 1);
    step();
    step();
    check("t3_clean_en",   mem_enable_o, 1);
    check("t3_clean_wr",   mem_write_o, 0);
    check("t3_clean_addr", mem_addr_o, 32'h0000_0100);
    mem_data_i = blk_a; mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    #1;
    check("t3_refill_data", cpu_data_o, 32'h1234_5678);

    // Dirty the line again, then reset in the middle of the write-back.
    cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b1; cpu_data_i = 32'h0BAD_F00D;
    step();
    cpu_MemWrite_i = 1'b0; cpu_MemRead_i = 1'b1; cpu_addr_i = 32'h0000_0304;
    step();
    step();
    check("t5_wb_en",  mem_enable_o, 1);
    check("t5_wb_wr",  mem_write_o, 1);
    rst_i = 1'b1; cpu_MemRead_i = 1'b0;
    step();
    rst_i = 1'b0;
    #1;
    check("t5_rst_en",    mem_enable_o, 0);
    check("t5_rst_stall", cpu_stall_o, 0);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    #1;
    check("t5_late_ack_en", mem_enable_o, 0);
    cpu_addr_i = 32'h0000_0104; cpu_MemRead_i = 1'b1;
    #1;
    check("t5_miss_stall", cpu_stall_o, 1);
    check("t5_miss_data",  cpu_data_o, 0);
    step();
    step();
    check("t5_al_en",   mem_enable_o, 1);
    check("t5_al_wr",   mem_write_o, 0);
    check("t5_al_addr", mem_addr_o, 32'h0000_0100);
    mem_data_i = blk_a; mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    #1;
    check("t5_rel_data", cpu_data_o, 32'h1234_5678);

    // Idle cycles with random addresses and data must not disturb anything.
    cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cpu_addr_i = $urandom; cpu_data_i = $urandom;
      mem_ack_i  = (i % 5) == 0;
      #1;
      check("t6_stall", cpu_stall_o, 0);
      check("t6_en",    mem_enable_o, 0);
      step();
    end
    mem_ack_i = 1'b0;
    cpu_addr_i = 32'h0000_0108; cpu_MemRead_i = 1'b1;
    #1;
    check("t6_hit_stall", cpu_stall_o, 0);
    check("t6_hit_data",  cpu_data_o, 32'hCAFE_F00D);
    cpu_addr_i = 32'h0000_0104;
    #1;
    check("t6_hit_data2", cpu_data_o, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
